// File: rtl/reg_view_scan.sv
// Register-file viewer: captures one sccomp register at a time (auto sweep or manual pick)
// and scans the latched 32-bit value onto an 8-digit active-low seven-segment display.
module reg_view_scan #(
    parameter int DWELL    = 50000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        auto_mode,
    input  logic [4:0]  sw_sel,
    input  logic        freeze,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [31:0] shown_data,
    output logic [4:0]  shown_idx,
    output logic        cap_valid,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW-1:0] DIV_LAST   = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_SEL     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t         state_r;
    logic [4:0]     reg_sel_r;
    logic [31:0]    shown_data_r;
    logic [4:0]     shown_idx_r;
    logic           cap_valid_r;
    logic [DW-1:0]  dwell_cnt_r;
    logic [SW-1:0]  div_cnt_r;
    logic [2:0]     digit_r;
    logic [7:0]     disp_an_r;
    logic [7:0]     disp_seg_r;
    logic [4:0]     next_idx_s;
    logic           manual_jump_s;
    logic           dwell_done_s;
    logic [3:0]     nibble_s;

    // Active-low seven-segment pattern {dp,g,f,e,d,c,b,a}; dp is kept dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // HOLD-exit decisions: next index to select, and whether a manual re-pick bypasses the dwell.
    always_comb begin
        next_idx_s    = sw_sel;
        manual_jump_s = 1'b0;
        dwell_done_s  = (dwell_cnt_r == DWELL_LAST);
        if (auto_mode) begin
            next_idx_s    = reg_sel_r + 5'd1;
            manual_jump_s = 1'b0;
        end else begin
            next_idx_s    = sw_sel;
            manual_jump_s = (sw_sel != reg_sel_r);
        end
    end

    // Capture FSM: select, settle, capture, then dwell (or jump) before the next selection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_SEL;
            reg_sel_r    <= 5'd0;
            shown_data_r <= 32'd0;
            shown_idx_r  <= 5'd0;
            cap_valid_r  <= 1'b0;
            dwell_cnt_r  <= '0;
        end else begin
            cap_valid_r <= 1'b0;
            case (state_r)
                ST_SEL: begin
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    shown_data_r <= reg_data;
                    shown_idx_r  <= reg_sel_r;
                    cap_valid_r  <= 1'b1;
                    dwell_cnt_r  <= '0;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD: begin
                    // freeze pins both the dwell count and the selection
                    if (freeze) begin
                        state_r <= ST_HOLD;
                    end else if (manual_jump_s || dwell_done_s) begin
                        reg_sel_r <= next_idx_s;
                        state_r   <= ST_SEL;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_SEL;
                end
            endcase
        end
    end

    // Pick the nibble of the latched value belonging to the active digit.
    always_comb begin
        nibble_s = 4'h0;
        case (digit_r)
            3'd0:    nibble_s = shown_data_r[3:0];
            3'd1:    nibble_s = shown_data_r[7:4];
            3'd2:    nibble_s = shown_data_r[11:8];
            3'd3:    nibble_s = shown_data_r[15:12];
            3'd4:    nibble_s = shown_data_r[19:16];
            3'd5:    nibble_s = shown_data_r[23:20];
            3'd6:    nibble_s = shown_data_r[27:24];
            3'd7:    nibble_s = shown_data_r[31:28];
            default: nibble_s = 4'h0;
        endcase
    end

    // Free-running digit scan divider; runs regardless of the capture FSM or freeze.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_r <= '0;
            digit_r   <= 3'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            digit_r   <= digit_r + 3'd1;
        end else begin
            div_cnt_r <= div_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // Registered digit enable and segment drive for the active digit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_an_r  <= 8'hFE;
            disp_seg_r <= 8'hC0;
        end else begin
            disp_an_r  <= ~(8'h01 << digit_r);
            disp_seg_r <= hex_to_seg(nibble_s);
        end
    end

    assign reg_sel    = reg_sel_r;
    assign shown_data = shown_data_r;
    assign shown_idx  = shown_idx_r;
    assign cap_valid  = cap_valid_r;
    assign disp_an    = disp_an_r;
    assign disp_seg   = disp_seg_r;

endmodule

// File: tb/tb_reg_view_scan.sv
// Directed bench for reg_view_scan with DWELL=8, SCAN_DIV=4; reg_data modelled as 0x1000_0000 + reg_sel.
module tb_reg_view_scan;

    logic        clk;
    logic        rstn;
    logic        auto_mode;
    logic [4:0]  sw_sel;
    logic        freeze;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel;
    logic [31:0] shown_data;
    logic [4:0]  shown_idx;
    logic        cap_valid;
    logic [7:0]  disp_an;
    logic [7:0]  disp_seg;

    logic        ovr;
    logic [31:0] ovr_val;
    int          vectors;
    int          miscompares;

    localparam logic [7:0] EXP_SEG [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    reg_view_scan #(.DWELL(8), .SCAN_DIV(4)) dut (
        .clk(clk), .rstn(rstn), .auto_mode(auto_mode), .sw_sel(sw_sel), .freeze(freeze),
        .reg_data(reg_data), .reg_sel(reg_sel), .shown_data(shown_data), .shown_idx(shown_idx),
        .cap_valid(cap_valid), .disp_an(disp_an), .disp_seg(disp_seg)
    );

    assign reg_data = ovr ? ovr_val : (32'h1000_0000 + {27'd0, reg_sel});

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(output bit got, output int n);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n++;
            if (cap_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; auto_mode = 1'b1; sw_sel = 5'd0; freeze = 1'b0; ovr = 1'b0; ovr_val = 32'd0;
        #12;
        vectors++; if (reg_sel !== 5'd0) begin miscompares++; $display("FAIL rst_reg_sel: got %0h expected 0", reg_sel); end
        vectors++; if (shown_data !== 32'd0) begin miscompares++; $display("FAIL rst_shown_data: got %08h expected 00000000", shown_data); end
        vectors++; if (shown_idx !== 5'd0) begin miscompares++; $display("FAIL rst_shown_idx: got %0h expected 0", shown_idx); end
        vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cap_valid: got %0b expected 0", cap_valid); end
        vectors++; if (disp_an !== 8'hFE) begin miscompares++; $display("FAIL rst_disp_an: got %02h expected FE", disp_an); end
        vectors++; if (disp_seg !== 8'hC0) begin miscompares++; $display("FAIL rst_disp_seg: got %02h expected C0", disp_seg); end
    endtask

    task automatic test_auto_first();
        rstn = 1'b1;
        tick(); tick();
        vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL first_edge2_cap: got %0b expected 0", cap_valid); end
        tick();
        vectors++; if (cap_valid !== 1'b1) begin miscompares++; $display("FAIL first_edge3_cap: got %0b expected 1", cap_valid); end
        vectors++; if (shown_data !== 32'h1000_0000) begin miscompares++; $display("FAIL first_data: got %08h expected 10000000", shown_data); end
        vectors++; if (shown_idx !== 5'd0) begin miscompares++; $display("FAIL first_idx: got %0d expected 0", shown_idx); end
        tick();
        vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL first_pulse_len: got %0b expected 0", cap_valid); end
        repeat (6) tick();
        vectors++; if (reg_sel !== 5'd0) begin miscompares++; $display("FAIL dwell_early_sel: got %0d expected 0", reg_sel); end
        tick();
        vectors++; if (reg_sel !== 5'd1) begin miscompares++; $display("FAIL dwell_sel: got %0d expected 1", reg_sel); end
        tick(); tick();
        vectors++; if (cap_valid !== 1'b0 || shown_data !== 32'h1000_0000) begin miscompares++; $display("FAIL second_pre: got cap=%0b data=%08h expected cap=0 data=10000000", cap_valid, shown_data); end
        tick();
        vectors++; if (cap_valid !== 1'b1 || shown_data !== 32'h1000_0001 || shown_idx !== 5'd1) begin miscompares++; $display("FAIL second_cap: got cap=%0b data=%08h idx=%0d expected 1/10000001/1", cap_valid, shown_data, shown_idx); end
    endtask

    task automatic test_auto_wrap();
        bit got;
        int n;
        bit reached;
        reached = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wait_cap(got, n);
            if (got && shown_idx === 5'd31) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++; if (!reached || shown_data !== 32'h1000_001F) begin miscompares++; $display("FAIL wrap_31: got reached=%0b data=%08h expected 1/1000001F", reached, shown_data); end
        wait_cap(got, n);
        vectors++; if (!got || n != 11) begin miscompares++; $display("FAIL wrap_period: got got=%0b cycles=%0d expected 1/11", got, n); end
        vectors++; if (shown_idx !== 5'd0 || shown_data !== 32'h1000_0000 || reg_sel !== 5'd0) begin miscompares++; $display("FAIL wrap_0: got idx=%0d data=%08h sel=%0d expected 0/10000000/0", shown_idx, shown_data, reg_sel); end
    endtask

    task automatic test_manual();
        bit got;
        int n;
        auto_mode = 1'b0; sw_sel = 5'd7;
        tick();
        vectors++; if (reg_sel !== 5'd7 || cap_valid !== 1'b0) begin miscompares++; $display("FAIL man_sel: got sel=%0d cap=%0b expected 7/0", reg_sel, cap_valid); end
        tick(); tick();
        vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL man_pre: got %0b expected 0", cap_valid); end
        tick();
        vectors++; if (cap_valid !== 1'b1 || shown_data !== 32'h1000_0007 || shown_idx !== 5'd7) begin miscompares++; $display("FAIL man_cap: got cap=%0b data=%08h idx=%0d expected 1/10000007/7", cap_valid, shown_data, shown_idx); end
        wait_cap(got, n);
        vectors++; if (!got || n != 11 || shown_idx !== 5'd7) begin miscompares++; $display("FAIL man_refresh: got got=%0b cycles=%0d idx=%0d expected 1/11/7", got, n, shown_idx); end
    endtask

    task automatic test_freeze();
        auto_mode = 1'b1;
        repeat (3) tick();
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++; if (cap_valid !== 1'b0 || reg_sel !== 5'd7) begin miscompares++; $display("FAIL frz_hold[%0d]: got cap=%0b sel=%0d expected 0/7", i, cap_valid, reg_sel); end
        end
        freeze = 1'b0;
        repeat (4) tick();
        vectors++; if (reg_sel !== 5'd7) begin miscompares++; $display("FAIL frz_resume_early: got %0d expected 7", reg_sel); end
        tick();
        vectors++; if (reg_sel !== 5'd8) begin miscompares++; $display("FAIL frz_resume: got %0d expected 8", reg_sel); end
        // freeze raised while a capture is already in flight must not stop it
        ovr_val = 32'h1234_ABCD; ovr = 1'b1; freeze = 1'b1;
        tick(); tick();
        vectors++; if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL frz_inflight_pre: got %0b expected 0", cap_valid); end
        tick();
        vectors++; if (cap_valid !== 1'b1 || shown_data !== 32'h1234_ABCD || shown_idx !== 5'd8) begin miscompares++; $display("FAIL frz_inflight_cap: got cap=%0b data=%08h idx=%0d expected 1/1234ABCD/8", cap_valid, shown_data, shown_idx); end
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++; if (cap_valid !== 1'b0 || reg_sel !== 5'd8) begin miscompares++; $display("FAIL frz_hold2[%0d]: got cap=%0b sel=%0d expected 0/8", i, cap_valid, reg_sel); end
        end
    endtask

    task automatic test_display();
        bit found;
        logic [7:0] prev;
        found = 1'b0;
        prev = disp_an;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev === 8'h7F && disp_an === 8'hFE) begin
                found = 1'b1;
                break;
            end
            prev = disp_an;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL disp_sync: got no 7F->FE transition expected one within 40 cycles"); end
        for (int d = 0; d < 8; d++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] exp_an;
                if (d > 0 || k > 0) tick();
                exp_an = ~(8'h01 << d);
                vectors++; if (disp_an !== exp_an || disp_seg !== EXP_SEG[d]) begin miscompares++; $display("FAIL disp_digit%0d_c%0d: got an=%02h seg=%02h expected an=%02h seg=%02h", d, k, disp_an, disp_seg, exp_an, EXP_SEG[d]); end
            end
        end
        tick();
        vectors++; if (disp_an !== 8'hFE || disp_seg !== 8'hA1) begin miscompares++; $display("FAIL disp_wrap: got an=%02h seg=%02h expected FE/A1", disp_an, disp_seg); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        freeze = 1'b0; ovr = 1'b0; auto_mode = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (reg_sel === 5'd9) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL mid_sel9: got sel=%0d expected 9 within 20 cycles", reg_sel); end
        tick();
        rstn = 1'b0;
        #1;
        vectors++; if (reg_sel !== 5'd0 || shown_data !== 32'd0 || shown_idx !== 5'd0 || cap_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_state: got sel=%0d data=%08h idx=%0d cap=%0b expected 0/0/0/0", reg_sel, shown_data, shown_idx, cap_valid); end
        vectors++; if (disp_an !== 8'hFE || disp_seg !== 8'hC0) begin miscompares++; $display("FAIL mid_rst_disp: got an=%02h seg=%02h expected FE/C0", disp_an, disp_seg); end
        auto_mode = 1'b0; sw_sel = 5'd5;
        tick();
        vectors++; if (cap_valid !== 1'b0 || shown_data !== 32'd0) begin miscompares++; $display("FAIL mid_rst_held: got cap=%0b data=%08h expected 0/0", cap_valid, shown_data); end
        rstn = 1'b1;
        tick(); tick();
        vectors++; if (cap_valid !== 1'b0 || shown_data !== 32'd0) begin miscompares++; $display("FAIL post_rst_pre: got cap=%0b data=%08h expected 0/0", cap_valid, shown_data); end
        tick();
        vectors++; if (cap_valid !== 1'b1 || shown_idx !== 5'd0 || shown_data !== 32'h1000_0000) begin miscompares++; $display("FAIL post_rst_cap0: got cap=%0b idx=%0d data=%08h expected 1/0/10000000", cap_valid, shown_idx, shown_data); end
        tick();
        vectors++; if (reg_sel !== 5'd5) begin miscompares++; $display("FAIL post_rst_jump: got %0d expected 5", reg_sel); end
        tick(); tick(); tick();
        vectors++; if (cap_valid !== 1'b1 || shown_idx !== 5'd5 || shown_data !== 32'h1000_0005) begin miscompares++; $display("FAIL post_rst_cap5: got cap=%0b idx=%0d data=%08h expected 1/5/10000005", cap_valid, shown_idx, shown_data); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_auto_first();
        test_auto_wrap();
        test_manual();
        test_freeze();
        test_display();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
